// File: rtl/sync_fifo_pkg.sv
// Shared types and constants for the synchronous FIFO read-side engine.
package sync_fifo_pkg;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} fifo_rd_state_t;

  localparam int unsigned RD_BUF_DEPTH = 2;
  localparam int unsigned RD_BUF_CNT_W = $clog2(RD_BUF_DEPTH + 1);

endpackage

// File: rtl/sync_fifo_skid_buffer.sv
// Two-entry in-order register buffer; absorbs the FIFO read latency so the
// reader can keep streaming while the consumer stalls.
module sync_fifo_skid_buffer
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    wr_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    pop_i,
  output logic [DATA_WIDTH-1:0]   head_o,
  output logic [RD_BUF_CNT_W-1:0] count_o
);

  logic [DATA_WIDTH-1:0]   head_q, head_d, tail_q, tail_d;
  logic [RD_BUF_CNT_W-1:0] count_q, count_d;

  // Head is always the oldest word; a pop shifts the tail forward.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({wr_i, pop_i})
      2'b10: begin
        if (count_q == '0) head_d = wr_data_i;
        else               tail_d = wr_data_i;
        count_d = count_q + RD_BUF_CNT_W'(1);
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - RD_BUF_CNT_W'(1);
      end
      2'b11: begin
        if (count_q == RD_BUF_CNT_W'(1)) begin
          head_d = wr_data_i;
        end else begin
          head_d = tail_q;
          tail_d = wr_data_i;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/sync_fifo_burst_reader.sv
// Burst read engine: pops len_i words from a sync_fifo and streams them out
// over valid/ready, one word per cycle when unthrottled.
module sync_fifo_burst_reader
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fifo_read_o,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i
);

  localparam int unsigned OCC_W = RD_BUF_CNT_W + 1;

  fifo_rd_state_t          state_q, state_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [LEN_WIDTH-1:0]    issued_q, issued_d;
  logic [LEN_WIDTH-1:0]    delivered_q, delivered_d;
  logic                    inflight_q;
  logic                    done_q, done_d;
  logic [RD_BUF_CNT_W-1:0] buf_count;
  logic [OCC_W-1:0]        occupancy_c;
  logic                    pop_c, space_c, read_c;

  // A read is allowed only if its word is guaranteed a buffer slot on arrival.
  assign pop_c       = m_valid_o & m_ready_i;
  assign occupancy_c = OCC_W'(buf_count) + OCC_W'(inflight_q);
  assign space_c     = occupancy_c < (OCC_W'(RD_BUF_DEPTH) + OCC_W'(pop_c));
  assign read_c      = (state_q == BURST) && !fifo_empty_i &&
                       (issued_q < len_q) && space_c;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            len_d       = len_i;
            issued_d    = '0;
            delivered_d = '0;
            state_d     = BURST;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      BURST: begin
        if (read_c) issued_d = issued_q + LEN_WIDTH'(1);
        if (pop_c)  delivered_d = delivered_q + LEN_WIDTH'(1);
        if (read_c && (issued_q + LEN_WIDTH'(1) == len_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop_c) begin
          delivered_d = delivered_q + LEN_WIDTH'(1);
          if (delivered_q + LEN_WIDTH'(1) == len_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      inflight_q  <= read_c;
      done_q      <= done_d;
    end
  end

  sync_fifo_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .wr_i     (inflight_q),
    .wr_data_i(fifo_rd_data_i),
    .pop_i    (pop_c),
    .head_o   (m_data_o),
    .count_o  (buf_count)
  );

  assign m_valid_o   = (buf_count != '0);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign fifo_read_o = read_c;

endmodule

// File: tb/tb_sync_fifo_burst_reader.sv
// Bench for sync_fifo_burst_reader: FIFO model + burst-level scoreboard.
module tb_sync_fifo_burst_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 8;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          start_i = 1'b0;
  logic [LW-1:0] len_i = '0;
  logic          busy_o, done_o, fifo_read_o, m_valid_o;
  logic          fifo_empty_i = 1'b1;
  logic [DW-1:0] fifo_rd_data_i = '0;
  logic [DW-1:0] m_data_o;
  logic          m_ready_i = 1'b1;

  sync_fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .start_i       (start_i),
    .len_i         (len_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .fifo_read_o   (fifo_read_o),
    .fifo_empty_i  (fifo_empty_i),
    .fifo_rd_data_i(fifo_rd_data_i),
    .m_valid_o     (m_valid_o),
    .m_data_o      (m_data_o),
    .m_ready_i     (m_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Words written by the stimulus; the FIFO model absorbs them at its own pace.
  logic [DW-1:0] src_mem [0:1023];
  int            src_wr = 0;
  int            src_rd = 0;
  logic [DW-1:0] fifo_mem [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got [0:1023];
  int            got_n = 0;
  logic [DW-1:0] nxt_rd = '0;
  bit            nxt_empty = 1'b1;
  int            ready_mode = 0;

  bit            m_busy = 0, m_done = 0, prev_stall = 0, done_nxt;
  int            m_len = 0, m_reads = 0, m_hs = 0;
  logic [DW-1:0] prev_data = '0;

  // Compare + model process: observes each cycle at the falling edge.
  always @(negedge clk_i) begin
    logic [DW-1:0] w;
    bit hs;
    hs = m_valid_o & m_ready_i;
    if (!rst_n_i) begin
      m_busy = 0; m_done = 0; m_reads = 0; m_hs = 0; prev_stall = 0;
      exp_q.delete();
    end else begin
      chk(busy_o == m_busy, "busy", 64'(busy_o), 64'(m_busy));
      chk(done_o == m_done, "done", 64'(done_o), 64'(m_done));
      if (fifo_read_o) begin
        chk(!fifo_empty_i && fifo_mem.size() != 0, "rd_while_empty", 64'(fifo_empty_i), 64'(0));
        chk(m_busy && m_reads < m_len, "rd_count", 64'(m_reads), 64'(m_len));
        chk(m_reads + 1 - m_hs - int'(hs) <= 2, "rd_space", 64'(m_reads + 1 - m_hs - int'(hs)), 64'(2));
      end
      if (m_valid_o) chk(m_busy, "valid_idle", 64'(m_valid_o), 64'(m_busy));
      if (prev_stall) chk(m_valid_o && m_data_o == prev_data, "hold", 64'(m_data_o), 64'(prev_data));
      if (hs) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "extra_word", 64'(m_data_o), 64'(0));
        end else begin
          w = exp_q.pop_front();
          chk(m_data_o == w, "data", 64'(m_data_o), 64'(w));
        end
        got[got_n] = m_data_o;
        got_n++;
      end
      done_nxt = 0;
      if (m_busy) begin
        m_reads += int'(fifo_read_o);
        m_hs    += int'(hs);
        if (m_hs == m_len) begin
          m_busy   = 0;
          done_nxt = 1;
        end
      end else if (start_i) begin
        if (len_i != '0) begin
          m_busy = 1; m_len = int'(len_i); m_reads = 0; m_hs = 0;
        end else begin
          done_nxt = 1;
        end
      end
      m_done     = done_nxt;
      prev_stall = m_valid_o & !m_ready_i;
      prev_data  = m_data_o;
      if (fifo_read_o && fifo_mem.size() != 0) begin
        w      = fifo_mem.pop_front();
        nxt_rd = w;
        exp_q.push_back(w);
      end
    end
    while (src_rd < src_wr) begin
      fifo_mem.push_back(src_mem[src_rd]);
      src_rd++;
    end
    nxt_empty = (fifo_mem.size() == 0);
  end

  always @(posedge clk_i) begin
    fifo_rd_data_i <= nxt_rd;
    fifo_empty_i   <= nxt_empty;
  end

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      case (ready_mode)
        0:       m_ready_i = 1'b1;
        1:       m_ready_i = ~m_ready_i;
        default: m_ready_i = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic push(input logic [DW-1:0] w);
    src_mem[src_wr] = w;
    src_wr++;
  endtask

  task automatic start_burst(input int n);
    start_i = 1'b1;
    len_i   = LW'(n);
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    step();
    while (busy_o && n < budget) begin
      step();
      n++;
    end
    chk(!busy_o, name, 64'(busy_o), 64'(0));
  endtask

  initial begin
    int base;
    int n, k;
    logic [DW-1:0] t3_exp [8];

    repeat (3) step();
    chk(busy_o == 0, "rst_busy", 64'(busy_o), 64'(0));
    chk(done_o == 0, "rst_done", 64'(done_o), 64'(0));
    chk(fifo_read_o == 0, "rst_read", 64'(fifo_read_o), 64'(0));
    chk(m_valid_o == 0, "rst_valid", 64'(m_valid_o), 64'(0));
    chk(m_data_o == 0, "rst_data", 64'(m_data_o), 64'(0));
    rst_n_i = 1'b1;
    repeat (2) step();

    // Latency/throughput trace for a 4-word burst.
    for (int i = 0; i < 4; i++) push(DW'(32'h10 + i));
    repeat (2) step();
    start_burst(4);
    for (int c = 1; c <= 8; c++) begin
      chk(fifo_read_o == (c >= 1 && c <= 4), "t1_read", 64'(fifo_read_o), 64'(c >= 1 && c <= 4));
      chk(m_valid_o == (c >= 3 && c <= 6), "t1_valid", 64'(m_valid_o), 64'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) chk(m_data_o == DW'(32'h10 + c - 3), "t1_data", 64'(m_data_o), 64'(32'h10 + c - 3));
      chk(done_o == (c == 7), "t1_done", 64'(done_o), 64'(c == 7));
      step();
    end

    // Zero-length request.
    push(32'hAA);
    repeat (2) step();
    start_burst(0);
    chk(done_o == 1, "t2_done", 64'(done_o), 64'(1));
    chk(busy_o == 0, "t2_busy", 64'(busy_o), 64'(0));
    chk(fifo_read_o == 0, "t2_read", 64'(fifo_read_o), 64'(0));
    step();
    chk(done_o == 0, "t2_done_clr", 64'(done_o), 64'(0));
    chk(fifo_mem.size() == 1, "t2_fifo_kept", 64'(fifo_mem.size()), 64'(1));

    // 8-word burst that stalls on an empty FIFO.
    push(32'hB1); push(32'hB2);
    repeat (2) step();
    base = got_n;
    t3_exp = '{32'hAA, 32'hB1, 32'hB2, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4};
    fork
      begin
        start_burst(8);
        wait_idle(200, "t3_timeout");
      end
      begin
        repeat (10) step();
        for (int i = 0; i < 5; i++) push(DW'(32'hC0 + i));
      end
    join
    for (int i = 0; i < 8; i++) chk(got[base + i] == t3_exp[i], "t3_order", 64'(got[base + i]), 64'(t3_exp[i]));

    // Alternating backpressure.
    ready_mode = 1;
    for (int i = 0; i < 6; i++) push($urandom);
    repeat (2) step();
    start_burst(6);
    wait_idle(200, "t4_timeout");
    ready_mode = 0;
    repeat (2) step();

    // Reset in the middle of an 8-word burst.
    for (int i = 0; i < 8; i++) push(DW'(32'h100 + i));
    repeat (2) step();
    start_burst(8);
    repeat (3) step();
    #1 rst_n_i = 1'b0;
    #1;
    chk(busy_o == 0, "t5_busy", 64'(busy_o), 64'(0));
    chk(done_o == 0, "t5_done", 64'(done_o), 64'(0));
    chk(fifo_read_o == 0, "t5_read", 64'(fifo_read_o), 64'(0));
    chk(m_valid_o == 0, "t5_valid", 64'(m_valid_o), 64'(0));
    chk(m_data_o == 0, "t5_data", 64'(m_data_o), 64'(0));
    step();
    rst_n_i = 1'b1;
    step();
    chk(fifo_mem.size() == 5, "t5_fifo_left", 64'(fifo_mem.size()), 64'(5));
    base = got_n;
    start_burst(2);
    wait_idle(100, "t5_timeout");
    chk(got[base] == 32'h103, "t5_word0", 64'(got[base]), 64'(32'h103));
    chk(got[base + 1] == 32'h104, "t5_word1", 64'(got[base + 1]), 64'(32'h104));
    start_burst(3);
    wait_idle(100, "t5_flush");

    // Start pulsed mid-burst is ignored.
    for (int i = 0; i < 8; i++) push(DW'(32'h200 + i));
    repeat (2) step();
    base = got_n;
    start_burst(3);
    step();
    start_i = 1'b1;
    len_i   = LW'(5);
    step();
    start_i = 1'b0;
    wait_idle(100, "t6_timeout");
    chk(fifo_mem.size() == 5, "t6_fifo_left", 64'(fifo_mem.size()), 64'(5));
    for (int i = 0; i < 3; i++) chk(got[base + i] == DW'(32'h200 + i), "t6_order", 64'(got[base + i]), 64'(32'h200 + i));
    start_burst(5);
    wait_idle(100, "t6_flush");

    // Randomized bursts, back-to-back starts, random FIFO fill and backpressure.
    ready_mode = 2;
    for (int b = 0; b < 12; b++) begin
      n = $urandom_range(0, 12);
      k = $urandom_range(0, n);
      for (int i = 0; i < k; i++) push($urandom);
      fork
        begin
          start_burst(n);
          wait_idle(400, "t7_timeout");
        end
        begin
          for (int i = 0; i < n - k; i++) begin
            repeat ($urandom_range(0, 3)) step();
            push($urandom);
          end
        end
      join
    end
    ready_mode = 0;
    repeat (4) step();
    chk(fifo_mem.size() == 0, "t7_fifo_empty", 64'(fifo_mem.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
